// File: rtl/padcfg_pkg.sv
// Shared types and helpers for the pad configuration sequencer.
// Address layout: the top two bits select the side, the low bits select the pad.
package padcfg_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_QUIESCE, ST_APPLY, ST_SETTLE} state_e;

  localparam int NSIDES = 4;
  localparam logic [1:0] SIDE_NO = 2'd0;
  localparam logic [1:0] SIDE_EA = 2'd1;
  localparam logic [1:0] SIDE_SO = 2'd2;
  localparam logic [1:0] SIDE_WE = 2'd3;

  function automatic logic [1:0] addr_side(input logic [31:0] addr, input int addrw);
    return 2'(addr >> (addrw - 2));
  endfunction

  function automatic logic [31:0] addr_pad(input logic [31:0] addr, input int addrw);
    return addr & ((32'd1 << (addrw - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/padcfg_bank.sv
// One padring side: shadow config written by the host, active config driven
// to the pads, and a whole-side shadow->active copy on the apply strobe.
module padcfg_bank
  #(parameter int NPINS = 9,
    parameter int CFGW  = 18,
    parameter int PADW  = 4,
    parameter logic [CFGW-1:0] CFG_RESET = '0)
  (input  logic                       clk,
   input  logic                       nreset,
   input  logic                       wr_en,
   input  logic [PADW-1:0]            pad,
   input  logic [CFGW-1:0]            wr_data,
   input  logic                       apply,
   output logic [CFGW-1:0]            rd_data,
   output logic [NPINS-1:0][CFGW-1:0] active);

  logic [NPINS-1:0][CFGW-1:0] shadow;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow <= {NPINS{CFG_RESET}};
      active <= {NPINS{CFG_RESET}};
    end else begin
      for (int i = 0; i < NPINS; i++)
        if (wr_en && pad == PADW'(i)) shadow[i] <= wr_data;
      if (apply) active <= shadow;
    end
  end

  // Out-of-range pad indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPINS; i++)
      if (pad == PADW'(i)) rd_data = shadow[i];
  end

endmodule

// File: rtl/padcfg_sequencer.sv
// Padring config owner: host writes a shadow store, commit runs a
// quiesce -> apply -> settle sequence with pad output enables forced off.
module padcfg_sequencer
  import padcfg_pkg::*;
  #(parameter int NPINS  = 9,
    parameter int CFGW   = 18,
    parameter int SETTLE = 8,
    parameter logic [CFGW-1:0] CFG_RESET = '0,
    parameter int ADDRW  = 2 + $clog2(NPINS))
  (input  logic                          clk,
   input  logic                          nreset,
   input  logic                          req_valid,
   input  logic                          req_write,
   input  logic [ADDRW-1:0]              req_addr,
   input  logic [CFGW-1:0]               req_wdata,
   output logic                          req_ready,
   output logic                          rsp_valid,
   output logic [CFGW-1:0]               rsp_rdata,
   output logic                          rsp_err,
   input  logic                          commit,
   output logic                          busy,
   output logic                          done,
   input  logic [NSIDES*NPINS-1:0]       core_oen,
   output logic [NSIDES*NPINS-1:0]       pad_oen,
   output logic [NSIDES*NPINS*CFGW-1:0]  pad_cfg);

  localparam int PADW = ADDRW - 2;
  localparam int CW   = $clog2(SETTLE + 1);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     side;
  logic           gate, pending;

  logic [1:0]      req_side;
  logic [PADW-1:0] req_pad;
  logic            pad_ok, accept;
  logic [NSIDES-1:0]                    wr_en, apply;
  logic [NSIDES-1:0][CFGW-1:0]          rd_data;
  logic [NSIDES-1:0][NPINS-1:0][CFGW-1:0] active;

  assign req_side  = addr_side(32'(req_addr), ADDRW);
  assign req_pad   = PADW'(addr_pad(32'(req_addr), ADDRW));
  assign pad_ok    = addr_pad(32'(req_addr), ADDRW) < 32'(NPINS);
  // Holding off requests during APPLY keeps the shadow stable mid-copy.
  assign req_ready = (state != ST_APPLY);
  assign accept    = req_valid & req_ready;
  assign busy      = (state != ST_IDLE);
  assign pad_oen   = core_oen | {(NSIDES*NPINS){gate}};
  assign pad_cfg   = active;

  for (genvar s = 0; s < NSIDES; s++) begin : g_bank
    assign wr_en[s] = accept & req_write & pad_ok & (req_side == 2'(s));
    assign apply[s] = (state == ST_APPLY) & (side == 2'(s));
    padcfg_bank #(.NPINS(NPINS), .CFGW(CFGW), .PADW(PADW), .CFG_RESET(CFG_RESET)) u_bank (
      .clk     (clk),
      .nreset  (nreset),
      .wr_en   (wr_en[s]),
      .pad     (req_pad),
      .wr_data (req_wdata),
      .apply   (apply[s]),
      .rd_data (rd_data[s]),
      .active  (active[s]));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept & (~req_write | ~pad_ok);
      rsp_err   <= accept & ~pad_ok;
      rsp_rdata <= (accept & ~req_write & pad_ok) ? rd_data[req_side] : '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      side    <= '0;
      gate    <= 1'b1;
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (commit && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_IDLE: if (commit) begin
          state <= ST_QUIESCE;
          gate  <= 1'b1;
          cnt   <= CW'(SETTLE - 1);
        end
        ST_QUIESCE: if (cnt == '0) begin
          state <= ST_APPLY;
          side  <= SIDE_NO;
        end else cnt <= cnt - 1'b1;
        ST_APPLY: begin
          side <= side + 1'b1;
          if (side == SIDE_WE) begin
            state <= ST_SETTLE;
            cnt   <= CW'(SETTLE - 1);
          end
        end
        ST_SETTLE: if (cnt == '0) begin
          done <= 1'b1;
          // A commit seen while busy chains straight into another sequence.
          if (pending || commit) begin
            state   <= ST_QUIESCE;
            cnt     <= CW'(SETTLE - 1);
            pending <= 1'b0;
          end else begin
            state <= ST_IDLE;
            gate  <= 1'b0;
          end
        end else cnt <= cnt - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_padcfg_sequencer.sv
// Scoreboard bench for padcfg_sequencer: a timeline model of the commit
// sequence plus shadow/active arrays predicts every cycle's outputs.
module tb_padcfg_sequencer;

  localparam int NPINS  = 9;
  localparam int CFGW   = 18;
  localparam int SETTLE = 8;
  localparam int LAT    = 2*SETTLE + 4;
  localparam int NP     = 4*NPINS;

  logic            clk = 1'b0;
  logic            nreset;
  logic            req_valid, req_write, req_ready;
  logic [5:0]      req_addr;
  logic [CFGW-1:0] req_wdata, rsp_rdata;
  logic            rsp_valid, rsp_err;
  logic            commit, busy, done;
  logic [NP-1:0]   core_oen, pad_oen;
  logic [NP*CFGW-1:0] pad_cfg;

  padcfg_sequencer dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .commit(commit), .busy(busy), .done(done),
    .core_oen(core_oen), .pad_oen(pad_oen), .pad_cfg(pad_cfg));

  always #5 clk = ~clk;

  int total = 0, bad = 0, done_cnt = 0;

  // Reference model: config arrays plus position k within the running sequence.
  logic [CFGW-1:0] sh  [4][NPINS];
  logic [CFGW-1:0] act [4][NPINS];
  bit run, pend, gate_m, done_m;
  int k;
  logic [CFGW:0] rq[$];

  task automatic chk(input string nm, input logic [NP*CFGW-1:0] a, input logic [NP*CFGW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < NPINS; p++) begin
        sh[s][p]  = '0;
        act[s][p] = '0;
      end
    run = 0; pend = 0; gate_m = 1; done_m = 0; k = 0;
    rq.delete();
  endtask

  function automatic bit in_apply();
    return run && k >= SETTLE && k <= SETTLE + 3;
  endfunction

  task automatic model_step(input bit cm, input bit v, input bit w,
                            input logic [5:0] a, input logic [CFGW-1:0] d);
    int s, p;
    bit copying;
    s = int'(a[5:4]);
    p = int'(a[3:0]);
    copying = in_apply();
    if (v && !copying) begin
      if (p >= NPINS) rq.push_back({1'b1, {CFGW{1'b0}}});
      else if (w) sh[s][p] = d;
      else rq.push_back({1'b0, sh[s][p]});
    end
    if (copying)
      for (int i = 0; i < NPINS; i++) act[k-SETTLE][i] = sh[k-SETTLE][i];
    done_m = 0;
    if (!run) begin
      if (cm) begin run = 1; k = 0; gate_m = 1; end
    end else begin
      k++;
      if (cm) pend = 1;
      if (k == LAT) begin
        done_m = 1;
        if (pend) begin k = 0; pend = 0; end
        else begin run = 0; gate_m = 0; end
      end
    end
  endtask

  function automatic logic [NP*CFGW-1:0] exp_cfg();
    logic [NP*CFGW-1:0] v;
    v = '0;
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < NPINS; p++) v[(s*NPINS+p)*CFGW +: CFGW] = act[s][p];
    return v;
  endfunction

  // Monitor: sample inputs at the edge, advance the model, check outputs 1ns later.
  initial begin
    logic [CFGW:0] e;
    model_reset();
    forever begin
      @(posedge clk);
      if (!nreset) model_reset();
      else model_step(commit, req_valid, req_write, req_addr, req_wdata);
      #1;
      if (done) done_cnt++;
      chk("busy", busy, run);
      chk("done", done, done_m);
      chk("req_ready", req_ready, !in_apply());
      chk("pad_oen", pad_oen, core_oen | {NP{gate_m}});
      chk("pad_cfg", pad_cfg, exp_cfg());
      chk("rsp_valid", rsp_valid, rq.size() != 0);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        if (rsp_valid) begin
          chk("rsp_err", rsp_err, e[CFGW]);
          chk("rsp_rdata", rsp_rdata, e[CFGW-1:0]);
        end
      end
    end
  end

  task automatic req(input bit w, input logic [5:0] a, input logic [CFGW-1:0] d);
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic pulse_commit();
    @(negedge clk); commit = 1;
    @(negedge clk); commit = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 2*LAT) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
  endtask

  initial begin
    int n, base;
    logic [5:0] a;
    nreset = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    commit = 0; core_oen = '0;
    repeat (3) @(negedge clk);
    nreset = 1;

    // write/read side 1 pad 3, then commit and time it
    a = {2'd1, 4'd3};
    req(1, a, 18'h2A5A5);
    req(0, a, '0);
    chk("cfg_before_commit", pad_cfg[12*CFGW +: CFGW], 18'h0);
    pulse_commit();
    wait_done(n);
    chk("commit_latency", n, LAT);
    @(negedge clk);
    chk("cfg_after_commit", pad_cfg[12*CFGW +: CFGW], 18'h2A5A5);
    chk("oen_open", pad_oen, '0);

    // pad index 12 is out of range
    a = {2'd1, 4'd12};
    req(1, a, 18'h3FFFF);
    req(0, a, '0);

    // commit again during QUIESCE, writes in QUIESCE and SETTLE
    base = done_cnt;
    pulse_commit();
    commit = 1; req_valid = 1; req_write = 1; req_addr = {2'd2, 4'd0}; req_wdata = 18'h1B3C7;
    @(negedge clk);
    commit = 0; req_valid = 0;
    repeat (12) @(negedge clk);
    req(1, {2'd3, 4'd8}, 18'h0F0F1);
    n = 0;
    while (done_cnt - base < 2 && n < 3*LAT) begin @(posedge clk); #1; n++; end
    repeat (5) @(negedge clk);
    chk("chained_done_pulses", done_cnt - base, 2);
    chk("cfg_so0", pad_cfg[18*CFGW +: CFGW], 18'h1B3C7);
    chk("cfg_we8", pad_cfg[35*CFGW +: CFGW], 18'h0F0F1);

    // reset during APPLY just after side 1 copied
    req(1, {2'd1, 4'd0}, 18'h12345);
    pulse_commit();
    repeat (SETTLE + 2) @(posedge clk);
    @(negedge clk);
    nreset = 0;
    #1;
    chk("rst_pad_oen", pad_oen, {NP{1'b1}});
    chk("rst_pad_cfg", pad_cfg, '0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    nreset = 1;
    req(1, {2'd0, 4'd5}, 18'h3FFFF);
    pulse_commit();
    wait_done(n);
    chk("commit_after_reset", n, LAT);
    @(negedge clk);
    chk("cfg_no5", pad_cfg[5*CFGW +: CFGW], 18'h3FFFF);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom);
      req_wdata = 18'($urandom);
      commit    = ($urandom_range(0, 29) == 0);
      core_oen  = NP'({$urandom(), $urandom()});
    end
    @(negedge clk);
    req_valid = 0; commit = 0;
    repeat (3*LAT) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
